// File: rtl/ls_mem_queue.sv
// Mem-stage load/store queue: buffers requests from Ex/Mem and issues them in order to the SDRAM
// controller over a req/ack handshake, returning load data and tag to Mem/WB.
module ls_mem_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 25,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_r_nW,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              stall,
  output logic              overflow,
  output logic              sd_req,
  output logic              sd_r_nW,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [DATA_W-1:0] sd_wdata,
  input  logic              sd_ack,
  input  logic              sd_rvalid,
  input  logic [DATA_W-1:0] sd_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [TAG_W-1:0]  wb_tag
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              r_nw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} state_t;

  entry_t           mem [DEPTH];
  entry_t           entry;
  entry_t           head;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] next_count;
  logic             push;
  logic             pop;
  logic             wb_fire;
  state_t           state;
  state_t           next_state;

  assign entry = {req_r_nW, req_addr, req_data, req_tag};
  assign head  = mem[rd_ptr];
  assign push  = req_valid && (count < CNT_W'(DEPTH));

  always_comb begin
    next_count = count;
    if (push && !pop)
      next_count = count + CNT_W'(1);
    else if (pop && !push)
      next_count = count - CNT_W'(1);
  end

  // Storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= entry;
  end

  // Pointers wrap naturally since DEPTH is a power of two; a full-queue request is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      stall    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count <= next_count;
      stall <= (next_count >= CNT_W'(DEPTH - 1));
      if (req_valid && !push)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (count != '0) next_state = ISSUE;
      ISSUE:     if (sd_ack) next_state = head.r_nw ? WAIT_DATA : IDLE;
      WAIT_DATA: if (sd_rvalid) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    pop     = 1'b0;
    wb_fire = 1'b0;
    case (state)
      ISSUE:     pop = sd_ack && !head.r_nw;
      WAIT_DATA: begin
        pop     = sd_rvalid;
        wb_fire = sd_rvalid;
      end
      default: begin
        pop     = 1'b0;
        wb_fire = 1'b0;
      end
    endcase
  end

  // Command fields load from the head when entering ISSUE and stay stable while it is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      sd_req   <= 1'b0;
      sd_r_nW  <= 1'b0;
      sd_addr  <= '0;
      sd_wdata <= '0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_tag   <= '0;
    end else begin
      sd_req <= (next_state == ISSUE);
      if (next_state == ISSUE) begin
        sd_r_nW  <= head.r_nw;
        sd_addr  <= head.addr;
        sd_wdata <= head.data;
      end else begin
        sd_r_nW  <= 1'b0;
        sd_addr  <= '0;
        sd_wdata <= '0;
      end
      wb_valid <= wb_fire && (head.tag != '0);
      if (wb_fire) begin
        wb_data <= sd_rdata;
        wb_tag  <= head.tag;
      end
    end
  end

endmodule

// File: tb/tb_ls_mem_queue.sv
// Bench for ls_mem_queue: directed scenarios and random traffic checked against a transaction-level
// model (request queue plus command/data phase) computed from the protocol rules.
module tb_ls_mem_queue;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic        rnw;
    logic [24:0] addr;
    logic [7:0]  data;
    logic [4:0]  tag;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_r_nW, sd_ack, sd_rvalid;
  logic [24:0] req_addr;
  logic [7:0]  req_data, sd_rdata;
  logic [4:0]  req_tag;
  logic        stall, overflow, sd_req, sd_r_nW, wb_valid;
  logic [24:0] sd_addr;
  logic [7:0]  sd_wdata, wb_data;
  logic [4:0]  wb_tag;

  ls_mem_queue dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_r_nW(req_r_nW), .req_addr(req_addr),
    .req_data(req_data), .req_tag(req_tag), .stall(stall), .overflow(overflow),
    .sd_req(sd_req), .sd_r_nW(sd_r_nW), .sd_addr(sd_addr), .sd_wdata(sd_wdata),
    .sd_ack(sd_ack), .sd_rvalid(sd_rvalid), .sd_rdata(sd_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_tag(wb_tag)
  );

  always #5 clk = ~clk;

  // Model: accepted requests in order; phase 0 = no command, 1 = command presented, 2 = awaiting load data.
  ent_t       mq[$];
  int         ph;
  logic       e_stall, e_ovf, e_wbv;
  logic [7:0] e_wbd;
  logic [4:0] e_wbt;
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic i_rst, input logic i_rv, input logic i_rnw,
                     input logic [24:0] i_addr, input logic [7:0] i_data, input logic [4:0] i_tag,
                     input logic i_ack, input logic i_rvalid, input logic [7:0] i_rdata);
    ent_t h;
    int   sz;
    logic pop;
    @(negedge clk);
    rst = i_rst; req_valid = i_rv; req_r_nW = i_rnw; req_addr = i_addr; req_data = i_data;
    req_tag = i_tag; sd_ack = i_ack; sd_rvalid = i_rvalid; sd_rdata = i_rdata;
    if (i_rst) begin
      mq.delete();
      ph = 0; e_stall = 1'b0; e_ovf = 1'b0; e_wbv = 1'b0; e_wbd = '0; e_wbt = '0;
    end else begin
      sz  = mq.size();
      h   = (sz > 0) ? mq[0] : '0;
      pop = 1'b0;
      e_wbv = 1'b0;
      if (ph == 0) begin
        if (sz > 0) ph = 1;
      end else if (ph == 1) begin
        if (i_ack) begin
          if (h.rnw) ph = 2;
          else begin ph = 0; pop = 1'b1; end
        end
      end else if (i_rvalid) begin
        e_wbv = (h.tag != 0); e_wbd = i_rdata; e_wbt = h.tag; pop = 1'b1; ph = 0;
      end
      if (pop) void'(mq.pop_front());
      if (i_rv) begin
        if (sz < int'(DEPTH)) mq.push_back('{rnw: i_rnw, addr: i_addr, data: i_data, tag: i_tag});
        else e_ovf = 1'b1;
      end
      e_stall = (mq.size() >= int'(DEPTH) - 1);
    end
    @(posedge clk);
    #1;
    check_eq("stall", 32'(stall), 32'(e_stall));
    check_eq("overflow", 32'(overflow), 32'(e_ovf));
    check_eq("sd_req", 32'(sd_req), 32'(ph == 1));
    check_eq("wb_valid", 32'(wb_valid), 32'(e_wbv));
    if (e_wbv) begin
      check_eq("wb_data", 32'(wb_data), 32'(e_wbd));
      check_eq("wb_tag", 32'(wb_tag), 32'(e_wbt));
    end
    if (ph == 1 && mq.size() > 0) begin
      h = mq[0];
      check_eq("sd_r_nW", 32'(sd_r_nW), 32'(h.rnw));
      check_eq("sd_addr", 32'(sd_addr), 32'(h.addr));
      if (!h.rnw) check_eq("sd_wdata", 32'(sd_wdata), 32'(h.data));
    end
    if (i_rst) begin
      check_eq("rst_sd_r_nW", 32'(sd_r_nW), 32'h0);
      check_eq("rst_sd_addr", 32'(sd_addr), 32'h0);
      check_eq("rst_sd_wdata", 32'(sd_wdata), 32'h0);
      check_eq("rst_wb_data", 32'(wb_data), 32'h0);
      check_eq("rst_wb_tag", 32'(wb_tag), 32'h0);
    end
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic push(input logic rnw, input logic [24:0] a, input logic [7:0] d, input logic [4:0] t);
    cyc(1'b0, 1'b1, rnw, a, d, t, 1'b0, 1'b0, '0);
  endtask

  // Acknowledge commands and return load data promptly until the model holds nothing.
  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (mq.size() == 0 && ph == 0) break;
      cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, ph == 1, ph == 2, 8'($urandom));
    end
    check_eq("drain_empty", 32'(mq.size()), 32'h0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_r_nW = 1'b0; req_addr = '0; req_data = '0; req_tag = '0;
    sd_ack = 1'b0; sd_rvalid = 1'b0; sd_rdata = '0;
    ph = 0; e_stall = 1'b0; e_ovf = 1'b0; e_wbv = 1'b0; e_wbd = '0; e_wbt = '0;
    do_reset();
    check_eq("reset_sd_req", 32'(sd_req), 32'h0);

    // Store held three cycles before ack.
    push(1'b0, 25'h0000123, 8'hA5, 5'd0);
    nop(1);
    check_eq("t1_sd_req_latency", 32'(sd_req), 32'h1);
    nop(2);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
    nop(3);

    // Load with data returned five cycles after ack.
    push(1'b1, 25'h1FFFFFF, 8'h00, 5'd7);
    nop(1);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
    nop(4);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 8'h3C);
    check_eq("t2_wb_data", 32'(wb_data), 32'h3C);
    nop(2);

    // Five back-to-back requests with ack withheld: stall, drop, overflow, then in-order drain.
    for (int i = 0; i < 5; i++) push(1'b0, 25'(32'h100 + i), 8'(8'h10 + i), 5'd0);
    check_eq("t3_overflow", 32'(overflow), 32'h1);
    drain(40);
    do_reset();

    // Push coinciding with a store pop at count 2.
    push(1'b0, 25'h0000AA, 8'h01, 5'd0);
    push(1'b0, 25'h0000BB, 8'h02, 5'd0);
    cyc(1'b0, 1'b1, 1'b0, 25'h0000CC, 8'h03, 5'd0, 1'b1, 1'b0, '0);
    check_eq("t4_count", 32'(mq.size()), 32'h2);
    drain(40);

    // Tag-0 load reaches SDRAM but never writes back.
    push(1'b1, 25'h0004321, 8'h00, 5'd0);
    nop(1);
    check_eq("t5_read_issued", 32'(sd_r_nW), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 8'h77);
    nop(1);

    // Reset while awaiting load data; the late data must be ignored.
    push(1'b1, 25'h0000555, 8'h00, 5'd5);
    nop(1);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
    nop(1);
    cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 8'h99);
    nop(3);

    // Random traffic with spurious ack/rvalid and rare resets.
    for (int i = 0; i < 3000; i++) begin
      logic rs, rv, ak, rvl;
      rs  = ($urandom_range(0, 499) == 0);
      rv  = e_stall ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 1);
      ak  = (ph == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      rvl = (ph == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      cyc(rs, rv, 1'($urandom), 25'($urandom), 8'($urandom),
          ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), ak, rvl, 8'($urandom));
    end
    drain(200);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
